rv_decapsulator: RTL and testbench

Receive-side counterpart of the trace encapsulator. It acts as an ATB sink: it accepts beats from the trace path's ATB output, unpacks them into a byte stream, and parses encapsulated packets. Each packet is a header byte, an optional timestamp and a payload. Every complete packet is presented on a valid/ready packet port for the trace-decoder model, an on-chip buffer or a debug bridge. It also issues ATB flush requests.

---
 rtl/rv_decapsulator_pkg.sv | 23 ++
 rtl/rv_atb_byte_unpacker.sv | 57 +++++
 rtl/rv_decapsulator.sv | 155 +++++++++++++++
 tb/tb_rv_decapsulator.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decapsulator_pkg.sv
// Shared encapsulation definitions: header field positions and parser states.
package rv_decapsulator_pkg;

    // Header byte layout
    localparam int unsigned HDR_LEN_LSB  = 0;
    localparam int unsigned HDR_LEN_MSB  = 4;
    localparam int unsigned HDR_TIME_BIT = 7;

    // Parser states
    typedef enum logic [2:0] {
        HDR,
        SKIP,
        TIME,
        PAY,
        OUT
    } parse_state_t;

    // Number of bytes in a timestamp field of the given width
    function automatic int unsigned t_bytes(input int unsigned t_len);
        return t_len / 8;
    endfunction

endpackage

// File: rtl/rv_atb_byte_unpacker.sv
// Single-entry ATB beat buffer that serialises an accepted beat into bytes.
module rv_atb_byte_unpacker #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        atvalid_i,
    output logic                        atready_o,
    input  logic [DATA_LEN-1:0]         atdata_i,
    input  logic [$clog2(DATA_LEN)-4:0] atbytes_i,
    input  logic [6:0]                  atid_i,
    output logic                        byte_valid,
    output logic [7:0]                  byte_data,
    output logic [6:0]                  byte_atid,
    input  logic                        byte_take
);

    localparam int unsigned BW = $clog2(DATA_LEN) - 3;

    logic                buf_valid;
    logic [DATA_LEN-1:0] buf_data;
    logic [BW-1:0]       buf_last;
    logic [BW-1:0]       rd_idx;
    logic [6:0]          buf_atid;
    logic                on_last;

    // A new beat may enter when the buffer is empty or its final byte leaves now
    assign on_last    = buf_valid && (rd_idx == buf_last);
    assign atready_o  = !buf_valid || (on_last && byte_take);
    assign byte_valid = buf_valid;
    assign byte_data  = 8'(buf_data >> {rd_idx, 3'b000});
    assign byte_atid  = buf_atid;

    // Beat load has priority over draining so the buffer refills without a gap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_last  <= '0;
            rd_idx    <= '0;
            buf_atid  <= '0;
        end else if (atvalid_i && atready_o) begin
            buf_valid <= 1'b1;
            buf_data  <= atdata_i;
            buf_last  <= atbytes_i;
            rd_idx    <= '0;
            buf_atid  <= atid_i;
        end else if (byte_take && buf_valid) begin
            if (on_last) begin
                buf_valid <= 1'b0;
            end else begin
                rd_idx <= rd_idx + BW'(1);
            end
        end
    end

endmodule

// File: rtl/rv_decapsulator.sv
// ATB sink that parses encapsulated trace packets and presents them on a packet port.
module rv_decapsulator
    import rv_decapsulator_pkg::*;
#(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned T_LEN       = 64,
    parameter int unsigned PAYLOAD_LEN = 248
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        atvalid_i,
    output logic                        atready_o,
    input  logic [DATA_LEN-1:0]         atdata_i,
    input  logic [$clog2(DATA_LEN)-4:0] atbytes_i,
    input  logic [6:0]                  atid_i,
    output logic                        afvalid_o,
    input  logic                        afready_i,
    input  logic                        flush_i,
    output logic                        pkt_valid_o,
    input  logic                        pkt_ready_i,
    output logic [4:0]                  pkt_length_o,
    output logic [PAYLOAD_LEN-1:0]      pkt_payload_o,
    output logic                        pkt_notime_o,
    output logic [T_LEN-1:0]            pkt_timestamp_o,
    output logic [6:0]                  pkt_atid_o,
    output logic [15:0]                 pkt_count_o
);

    localparam int unsigned T_BYTES = t_bytes(T_LEN);

    logic         byte_valid;
    logic [7:0]   byte_data;
    logic [6:0]   byte_atid;
    logic         byte_take;

    parse_state_t state, state_nxt;
    logic [7:0]   cnt;
    logic [4:0]   hdr_len;
    logic         hdr_time;
    logic         time_last;
    logic         pay_last;

    rv_atb_byte_unpacker #(
        .DATA_LEN (DATA_LEN)
    ) u_unpacker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .atvalid_i  (atvalid_i),
        .atready_o  (atready_o),
        .atdata_i   (atdata_i),
        .atbytes_i  (atbytes_i),
        .atid_i     (atid_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_atid  (byte_atid),
        .byte_take  (byte_take)
    );

    assign hdr_len     = byte_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_time    = byte_data[HDR_TIME_BIT];
    assign time_last   = (cnt == 8'(T_BYTES - 1));
    assign pay_last    = (cnt == ({3'b000, pkt_length_o} - 8'd1));
    assign byte_take   = byte_valid && (state != OUT);
    assign pkt_valid_o = (state == OUT);

    // Parser state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one byte per cycle in every state except OUT
    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (byte_valid) begin
                    if (hdr_len == 5'd0) begin
                        state_nxt = hdr_time ? SKIP : HDR;
                    end else begin
                        state_nxt = hdr_time ? TIME : PAY;
                    end
                end
            end
            SKIP:    if (byte_valid && time_last) state_nxt = HDR;
            TIME:    if (byte_valid && time_last) state_nxt = PAY;
            PAY:     if (byte_valid && pay_last)  state_nxt = OUT;
            OUT:     if (pkt_ready_i)             state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // Field capture and packet counter; the packet registers are only reloaded
    // by headers that start a real packet, so discarded headers leave them as is
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt             <= '0;
            pkt_length_o    <= '0;
            pkt_payload_o   <= '0;
            pkt_notime_o    <= 1'b0;
            pkt_timestamp_o <= '0;
            pkt_atid_o      <= '0;
            pkt_count_o     <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (byte_valid) begin
                        cnt <= '0;
                        if (hdr_len != 5'd0) begin
                            pkt_length_o    <= hdr_len;
                            pkt_notime_o    <= !hdr_time;
                            pkt_atid_o      <= byte_atid;
                            pkt_payload_o   <= '0;
                            pkt_timestamp_o <= '0;
                        end
                    end
                end
                SKIP: begin
                    if (byte_valid) cnt <= time_last ? 8'd0 : cnt + 8'd1;
                end
                TIME: begin
                    if (byte_valid) begin
                        pkt_timestamp_o <= pkt_timestamp_o | (T_LEN'(byte_data) << {cnt, 3'b000});
                        cnt             <= time_last ? 8'd0 : cnt + 8'd1;
                    end
                end
                PAY: begin
                    if (byte_valid) begin
                        pkt_payload_o <= pkt_payload_o | (PAYLOAD_LEN'(byte_data) << {cnt, 3'b000});
                        cnt           <= cnt + 8'd1;
                    end
                end
                OUT: begin
                    if (pkt_ready_i) pkt_count_o <= pkt_count_o + 16'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Flush request: set by a pulse, held until the source acknowledges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            afvalid_o <= 1'b0;
        end else if (afvalid_o) begin
            afvalid_o <= !afready_i;
        end else begin
            afvalid_o <= flush_i;
        end
    end

endmodule

// File: tb/tb_rv_decapsulator.sv
// Randomised and directed checks of rv_decapsulator against a byte-stream packet model.
module tb_rv_decapsulator;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         atvalid_i = 1'b0;
    logic         atready_o;
    logic [31:0]  atdata_i = '0;
    logic [1:0]   atbytes_i = '0;
    logic [6:0]   atid_i = '0;
    logic         afvalid_o;
    logic         afready_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         pkt_valid_o;
    logic         pkt_ready_i = 1'b0;
    logic [4:0]   pkt_length_o;
    logic [247:0] pkt_payload_o;
    logic         pkt_notime_o;
    logic [63:0]  pkt_timestamp_o;
    logic [6:0]   pkt_atid_o;
    logic [15:0]  pkt_count_o;

    rv_decapsulator #(
        .DATA_LEN    (32),
        .T_LEN       (64),
        .PAYLOAD_LEN (248)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .atvalid_i       (atvalid_i),
        .atready_o       (atready_o),
        .atdata_i        (atdata_i),
        .atbytes_i       (atbytes_i),
        .atid_i          (atid_i),
        .afvalid_o       (afvalid_o),
        .afready_i       (afready_i),
        .flush_i         (flush_i),
        .pkt_valid_o     (pkt_valid_o),
        .pkt_ready_i     (pkt_ready_i),
        .pkt_length_o    (pkt_length_o),
        .pkt_payload_o   (pkt_payload_o),
        .pkt_notime_o    (pkt_notime_o),
        .pkt_timestamp_o (pkt_timestamp_o),
        .pkt_atid_o      (pkt_atid_o),
        .pkt_count_o     (pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]   len;
        logic [247:0] pay;
        logic         notime;
        logic [63:0]  ts;
        logic [6:0]   id;
    } pkt_t;

    pkt_t        exp_q[$];
    logic [14:0] sq[$];           // {atid, byte} in stream order, not yet parsed
    logic [15:0] exp_count = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        forced_rdy = 1'b0;
    logic        rand_rdy = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parse every complete packet at the front of the received byte stream
    task automatic model_parse();
        logic [7:0] h;
        int         need;
        int         tb;
        pkt_t       p;
        while (sq.size() > 0) begin
            h  = sq[0][7:0];
            tb = h[7] ? 8 : 0;
            if (h[4:0] == 5'd0 && !h[7]) begin
                void'(sq.pop_front());
                continue;
            end
            need = 1 + tb + int'(h[4:0]);
            if (sq.size() < need) break;
            p.len    = h[4:0];
            p.notime = !h[7];
            p.id     = sq[0][14:8];
            p.pay    = '0;
            p.ts     = '0;
            for (int i = 0; i < tb; i++) p.ts |= 64'(sq[1 + i][7:0]) << (8 * i);
            for (int i = 0; i < int'(h[4:0]); i++) p.pay |= 248'(sq[1 + tb + i][7:0]) << (8 * i);
            for (int i = 0; i < need; i++) void'(sq.pop_front());
            if (p.len != 5'd0) exp_q.push_back(p);
        end
    endtask

    always @(negedge clk_i) pkt_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;

    // Protocol bookkeeping: a delivered packet leaves the model queue
    always @(posedge clk_i) begin
        if (!rst_i && pkt_valid_o && pkt_ready_i) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_count <= exp_count + 16'd1;
        end
    end

    // Output comparison against the model on every cycle
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("pkt_count", 256'(pkt_count_o), 256'(exp_count));
            if (pkt_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", 256'(pkt_valid_o), 256'(0));
                end else begin
                    check("pkt_length",    256'(pkt_length_o),    256'(exp_q[0].len));
                    check("pkt_payload",   256'(pkt_payload_o),   256'(exp_q[0].pay));
                    check("pkt_notime",    256'(pkt_notime_o),    256'(exp_q[0].notime));
                    check("pkt_timestamp", 256'(pkt_timestamp_o), 256'(exp_q[0].ts));
                    check("pkt_atid",      256'(pkt_atid_o),      256'(exp_q[0].id));
                end
            end
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [1:0] nb, input logic [6:0] id);
        @(negedge clk_i);
        atvalid_i = 1'b1;
        atdata_i  = d;
        atbytes_i = nb;
        atid_i    = id;
    endtask

    // Wait for the presented beat to be taken; returns the number of edges waited
    task automatic wait_accept(input logic [31:0] d, input logic [1:0] nb, input logic [6:0] id,
                               output int cyc);
        bit acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 500) begin
            #1;
            acc = atready_o;
            @(posedge clk_i);
            cyc++;
        end
        if (!acc) begin
            check("accept_timeout", 256'(0), 256'(1));
        end else begin
            for (int i = 0; i <= int'(nb); i++) sq.push_back({id, 8'(d >> (8 * i))});
            model_parse();
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] nb, input logic [6:0] id,
                             output int cyc);
        drive_beat(d, nb, id);
        wait_accept(d, nb, id, cyc);
    endtask

    task automatic idle();
        @(negedge clk_i);
        atvalid_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        #1;
        while (!pkt_valid_o && k < 200) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!pkt_valid_o) check(name, 256'(0), 256'(1));
    endtask

    task automatic wait_count(input logic [15:0] n);
        int k = 0;
        while (pkt_count_o != n && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("count_reached", 256'(pkt_count_o), 256'(n));
    endtask

    initial begin
        int         cyc;
        int         k;
        logic [7:0] bq[$];
        int         r;
        int         len;
        logic [31:0] d;
        int         n;
        logic [6:0] id;

        #12 wait_count(16'd0);
        // Reset values
        check("rst_atready", 256'(atready_o),   256'(1));
        check("rst_afvalid", 256'(afvalid_o),   256'(0));
        check("rst_valid",   256'(pkt_valid_o), 256'(0));
        check("rst_payload", 256'(pkt_payload_o), 256'(0));
        check("rst_count",   256'(pkt_count_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single-beat packet and its latency
        forced_rdy = 1'b0;
        send_beat(32'h33221103, 2'd3, 7'd5, cyc);
        idle();
        k = 0;
        while (!pkt_valid_o && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("t1_latency", 256'(k), 256'(4));
        check("t1_length",  256'(pkt_length_o),  256'(3));
        check("t1_payload", 256'(pkt_payload_o), 256'(24'h332211));
        check("t1_notime",  256'(pkt_notime_o),  256'(1));
        check("t1_atid",    256'(pkt_atid_o),    256'(5));
        forced_rdy = 1'b1;
        wait_count(16'd1);

        // Timestamped packet spanning three beats
        forced_rdy = 1'b0;
        send_beat(32'h03020182, 2'd3, 7'd9, cyc);
        send_beat(32'h07060504, 2'd3, 7'd10, cyc);
        send_beat(32'h00BBAA08, 2'd2, 7'd11, cyc);
        idle();
        wait_valid("t2_valid_timeout");
        check("t2_timestamp", 256'(pkt_timestamp_o), 256'(64'h0807060504030201));
        check("t2_payload",   256'(pkt_payload_o),   256'(16'hBBAA));
        check("t2_notime",    256'(pkt_notime_o),    256'(0));
        check("t2_atid",      256'(pkt_atid_o),      256'(9));
        forced_rdy = 1'b1;
        wait_count(16'd2);

        // Padding and back-to-back packets
        send_beat(32'h11010000, 2'd3, 7'd1, cyc);
        send_beat(32'h00002201, 2'd1, 7'd2, cyc);
        check("t3_no_bubble", 256'(cyc), 256'(4));
        idle();
        wait_valid("t3a_valid_timeout");
        check("t3a_payload", 256'(pkt_payload_o), 256'(8'h11));
        @(posedge clk_i);
        wait_valid("t3b_valid_timeout");
        check("t3b_payload", 256'(pkt_payload_o), 256'(8'h22));
        wait_count(16'd4);

        // Backpressure with a pending beat
        forced_rdy = 1'b0;
        send_beat(32'hB201A101, 2'd3, 7'd3, cyc);
        drive_beat(32'h0000C301, 2'd1, 7'd4);
        wait_valid("t4_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("t4_atready", 256'(atready_o),     256'(0));
            check("t4_valid",   256'(pkt_valid_o),   256'(1));
            check("t4_payload", 256'(pkt_payload_o), 256'(8'hA1));
            check("t4_atid",    256'(pkt_atid_o),    256'(3));
        end
        forced_rdy = 1'b1;
        wait_accept(32'h0000C301, 2'd1, 7'd4, cyc);
        idle();
        wait_count(16'd7);

        // Flush handshake
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t5_afvalid_held", 256'(afvalid_o), 256'(1));
            @(negedge clk_i);
        end
        afready_i = 1'b1;
        @(negedge clk_i);
        check("t5_afvalid_drop", 256'(afvalid_o), 256'(0));
        afready_i = 1'b0;

        // Asynchronous reset during payload
        send_beat(32'h33221105, 2'd3, 7'd6, cyc);
        idle();
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        sq.delete();
        exp_q.delete();
        exp_count = '0;
        #1;
        check("t6_atready", 256'(atready_o),       256'(1));
        check("t6_valid",   256'(pkt_valid_o),     256'(0));
        check("t6_afvalid", 256'(afvalid_o),       256'(0));
        check("t6_payload", 256'(pkt_payload_o),   256'(0));
        check("t6_length",  256'(pkt_length_o),    256'(0));
        check("t6_ts",      256'(pkt_timestamp_o), 256'(0));
        check("t6_count",   256'(pkt_count_o),     256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        forced_rdy = 1'b0;
        send_beat(32'h006B5A02, 2'd2, 7'd7, cyc);
        idle();
        wait_valid("t6_valid_timeout");
        check("t6_new_payload", 256'(pkt_payload_o), 256'(16'h6B5A));
        check("t6_new_atid",    256'(pkt_atid_o),    256'(7));
        forced_rdy = 1'b1;
        wait_count(16'd1);

        // Randomised packet stream in random beat sizes
        rand_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bq.push_back(8'h00);
            end else if (r == 1) begin
                bq.push_back(8'h80 | 8'($urandom_range(0, 3) << 5));
                for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
            end else begin
                len = $urandom_range(1, 31);
                bq.push_back(8'(len) | 8'($urandom_range(0, 3) << 5) | ($urandom_range(0, 1) != 0 ? 8'h80 : 8'h00));
                if (bq[bq.size() - 1][7]) for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
                for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            end
        end
        while (bq.size() > 0) begin
            n = $urandom_range(1, (bq.size() < 4) ? bq.size() : 4);
            d = 32'($urandom);
            for (int i = 0; i < n; i++) begin
                d &= ~(32'hFF << (8 * i));
                d |= 32'(bq.pop_front()) << (8 * i);
            end
            id = 7'($urandom);
            send_beat(d, 2'(n - 1), id, cyc);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
            end
        end
        idle();
        k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            @(negedge clk_i);
            k++;
        end
        check("drain", 256'(exp_q.size()), 256'(0));
        repeat (4) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
